pwm_capture: RTL and testbench
==============================

// Module: pwm_capture
// PURPOSE
//  Measures an incoming PWM waveform, as produced by the team's PWM generators (10 kHz
//  carrier at the 50 MHz system clock). For each complete period the block reports the
//  period length, the high time and the duty in permille. It also flags loss of signal.
//  Sits between the board input pin and any control/display logic that needs the duty.
// PARAMETERS
//  WIDTH        16     bit width of period/high_time counters and outputs
//  TIMEOUT      50000  cycles without a rising edge before no_signal is raised; must be <= 2^WIDTH-1
//  SYNC_STAGES  2      synchronizer flip-flops on pwm_in; minimum 2
// PORTS
//  clock      in   1      system clock, 50 MHz
//  reset      in   1      asynchronous, active-low reset
//  pwm_in     in   1      asynchronous PWM input
//  level      out  1      synchronized pwm_in, i.e. last synchronizer stage
//  period     out  WIDTH  clock cycles from one rising edge to the next (last completed period)
//  high_time  out  WIDTH  cycles the synchronized input was 1 within that period
//  duty       out  10     floor(high_time*1000/period), range 0..1000
//  valid      out  1      one-cycle pulse when period/high_time/duty update together
//  no_signal  out  1      1 = no valid measurement since reset or since the last timeout
// BEHAVIOUR
//  - Reset (reset=0, asynchronous):
//    - synchronizer, counters and divider cleared; state WAIT_EDGE.
//    - level=0, period=0, high_time=0, duty=0, valid=0, no_signal=1.
//    - Any divide in progress is aborted and produces no valid.
//  - Synchronization and edge detection:
//    - pwm_in passes through SYNC_STAGES flip-flops to form level.
//    - A rising edge is detected when level=1 and the previous level was 0.
//    - Edge detect therefore lags pwm_in by SYNC_STAGES+1 cycles.
//  - Counters:
//    - cnt_p and cnt_h are cleared to 0 on the edge-detect cycle.
//    - cnt_p increments on every later cycle.
//    - cnt_h increments on every later cycle with level=1.
//    - Both counters saturate at all-ones and never wrap.
//  - FSM:
//    - WAIT_EDGE: on a rising edge, clear the counters -> MEASURE.
//    - MEASURE, rising edge:
//      - latch P=cnt_p+1 and H=cnt_h+(1 for the edge cycle itself) into the divider;
//      - clear the counters -> DIVIDE.
//    - MEASURE, cnt_p reaches TIMEOUT-1 with no edge -> TIMEOUT state.
//    - DIVIDE: sequential restoring divider computes H*1000/P in exactly WIDTH+10 cycles.
//      - Result is clamped to 1000.
//      - Counters keep running during DIVIDE.
//      - On completion: period=P, high_time=H, duty=result, valid=1 for 1 cycle,
//        no_signal=0 -> MEASURE.
//      - valid asserts WIDTH+11 cycles after the edge-detect cycle; outputs hold until the next valid.
//    - DIVIDE with a rising edge arriving before completion:
//      - the current divide still completes and reports;
//      - the counters restart at that edge; no second result is queued;
//      - the next reported period is the one ending at the first edge seen in MEASURE.
//    - TIMEOUT (one cycle):
//      - period=0, high_time=0, duty=(level ? 1000 : 0), no_signal=1, valid=1 pulse;
//      - then -> WAIT_EDGE.
//  - Recovery: after a timeout, no_signal clears only at the next valid from DIVIDE.
//    This takes 2 rising edges plus the divide latency.
//  - Width rules:
//    - The divider numerator is WIDTH+10 bits.
//    - H<=P always, since high time is counted inside the same period.
//    - P>=1, so the divider never sees division by zero.
// TESTING
//  1. 5000-cycle period, 2500 high -> period=5000, high_time=2500, duty=500;
//     valid every 5000 cycles, no_signal=0 after the 2nd rising edge.
//  2. 5000-cycle period, high 5 then high 4999 -> duty=1, then duty=999; high_time matches exactly.
//  3. Running 10 kHz, then pwm_in held at 1 -> TIMEOUT cycles after the last edge:
//     valid pulse, period=0, duty=1000, no_signal=1. Restart the PWM ->
//     no_signal=0 at the first valid after the 2nd edge.
//  4. 20-cycle period, 10 high (shorter than the divide latency) ->
//     valid every 40 cycles, period=20, high_time=10, duty=500, never a wrong value.
//  5. reset pulsed low mid-DIVIDE -> outputs reset immediately, no valid pulse,
//     no_signal=1; measurement resumes normally after 2 edges.
//  6. 1-cycle high pulse every 5000 cycles -> high_time=1, duty=0 (floor).
//     Input held at 0 from reset -> no valid until TIMEOUT is reached from the first edge; no false edge.

Source files
------------

// File: rtl/pwm_capture.sv
// PWM capture: measures period, high time and duty (permille) of a synchronized PWM input
// and raises no_signal when no rising edge arrives for TIMEOUT cycles.
module pwm_capture #(
  parameter int WIDTH       = 16,
  parameter int TIMEOUT     = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pwm_in,
  output logic             level,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic [9:0]       duty,
  output logic             valid,
  output logic             no_signal
);

  localparam int NUMW = WIDTH + 10;
  localparam int CNTW = $clog2(NUMW);
  localparam logic [CNTW-1:0]  DIV_LAST     = CNTW'(NUMW - 1);
  localparam logic [CNTW-1:0]  DIV_ONE      = CNTW'(1);
  localparam logic [WIDTH-1:0] TIMEOUT_LAST = WIDTH'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] CNT_ONE      = WIDTH'(1);
  localparam logic [NUMW-1:0]  PERMILLE     = NUMW'(1000);
  localparam logic [9:0]       DUTY_FULL    = 10'd1000;

  localparam logic [1:0] S_WAIT_EDGE = 2'd0;
  localparam logic [1:0] S_MEASURE   = 2'd1;
  localparam logic [1:0] S_DIVIDE    = 2'd2;
  localparam logic [1:0] S_TIMEOUT   = 2'd3;

  logic [1:0]             state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_d;
  logic                   rise;

  logic [WIDTH-1:0] cnt_p;
  logic [WIDTH-1:0] cnt_h;
  logic [WIDTH-1:0] p_next;
  logic [WIDTH-1:0] h_next;

  logic [NUMW-1:0]  num_init;
  logic [NUMW-1:0]  div_num;
  logic [NUMW-2:0]  div_quo;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_den;
  logic [WIDTH-1:0] div_h;
  logic [CNTW-1:0]  div_cnt;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] rem_diff;
  logic             q_bit;
  logic [NUMW-1:0]  quo_final;
  logic [9:0]       duty_clamped;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      level_d <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      level_d <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~level_d;

  // Counters saturate so a stuck input can never wrap into a bogus short period.
  assign p_next = (&cnt_p) ? cnt_p : cnt_p + CNT_ONE;
  assign h_next = (&cnt_h) ? cnt_h : cnt_h + CNT_ONE;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_p <= '0;
      cnt_h <= '0;
    end else if (rise) begin
      cnt_p <= '0;
      cnt_h <= '0;
    end else begin
      cnt_p <= p_next;
      if (level) begin
        cnt_h <= h_next;
      end
    end
  end

  // The edge cycle itself is high, hence h_next rather than cnt_h as the latched high time.
  assign num_init = NUMW'(h_next) * PERMILLE;

  always_comb begin
    rem_shift    = {div_rem, div_num[NUMW-1]};
    q_bit        = (rem_shift >= {1'b0, div_den});
    rem_diff     = rem_shift[WIDTH-1:0] - div_den;
    quo_final    = {div_quo, q_bit};
    duty_clamped = (quo_final > PERMILLE) ? DUTY_FULL : quo_final[9:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_WAIT_EDGE;
      div_num   <= '0;
      div_quo   <= '0;
      div_rem   <= '0;
      div_den   <= '0;
      div_h     <= '0;
      div_cnt   <= '0;
      period    <= '0;
      high_time <= '0;
      duty      <= '0;
      valid     <= 1'b0;
      no_signal <= 1'b1;
    end else begin
      valid <= 1'b0;
      case (state)
        S_WAIT_EDGE: begin
          if (rise) begin
            state <= S_MEASURE;
          end
        end
        S_MEASURE: begin
          if (rise) begin
            div_num <= num_init;
            div_den <= p_next;
            div_h   <= h_next;
            div_rem <= '0;
            div_quo <= '0;
            div_cnt <= '0;
            state   <= S_DIVIDE;
          end else if (cnt_p == TIMEOUT_LAST) begin
            state <= S_TIMEOUT;
          end
        end
        // Edges seen here only restart the counters; the result publishes on the last step.
        S_DIVIDE: begin
          div_num <= {div_num[NUMW-2:0], 1'b0};
          div_quo <= quo_final[NUMW-2:0];
          div_rem <= q_bit ? rem_diff : rem_shift[WIDTH-1:0];
          div_cnt <= div_cnt + DIV_ONE;
          if (div_cnt == DIV_LAST) begin
            period    <= div_den;
            high_time <= div_h;
            duty      <= duty_clamped;
            valid     <= 1'b1;
            no_signal <= 1'b0;
            state     <= S_MEASURE;
          end
        end
        S_TIMEOUT: begin
          period    <= '0;
          high_time <= '0;
          duty      <= level ? DUTY_FULL : 10'd0;
          no_signal <= 1'b1;
          valid     <= 1'b1;
          state     <= S_WAIT_EDGE;
        end
        default: begin
          state <= S_WAIT_EDGE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Testbench for pwm_capture: directed PWM patterns checked every cycle against an
// edge-timestamp model of the measurement rules, plus hand-computed literal checks.
module tb_pwm_capture;

  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 6000;
  localparam int SYNC    = 2;
  localparam int LAT     = WIDTH + 11;
  localparam int MAXCYC  = 100000;

  logic             clock  = 1'b0;
  logic             reset  = 1'b0;
  logic             pwm_in = 1'b0;
  logic             level;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic [9:0]       duty;
  logic             valid;
  logic             no_signal;

  pwm_capture #(
    .WIDTH(WIDTH),
    .TIMEOUT(TIMEOUT),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .pwm_in(pwm_in),
    .level(level),
    .period(period),
    .high_time(high_time),
    .duty(duty),
    .valid(valid),
    .no_signal(no_signal)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int fails  = 0;
  int validSeen = 0;

  typedef struct {
    int at;
    int per;
    int hi;
    int dut;
    bit ns;
  } ev_t;

  ev_t evq[$];
  bit  pwmHist [0:MAXCYC];
  bit  lvlHist [0:MAXCYC];

  int  n = 0;
  int  running = 0;
  int  startCyc = 0;
  int  busyEnd = -1;
  int  waitFrom = 1;
  int  expPeriod = 0;
  int  expHigh = 0;
  int  expDuty = 0;
  bit  expNs = 1'b1;
  bit  expValid;
  bit  expLevel;
  bit  mRise;
  bit  mPrev;
  int  mH;
  int  mP;
  longint mQ;
  ev_t mEv;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      fails++;
      if (fails <= 50)
        $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d, t=%0t)", name, actual, expected, n, $time);
    end
  endtask

  // Level seen by the design at cycle k is pwm_in sampled SYNC-1 clock edges earlier.
  function automatic bit lvlAt(input int k);
    if (k - SYNC + 1 >= 1) return pwmHist[k-SYNC+1];
    return 1'b0;
  endfunction

  // Model: tracks period start edges, the busy window of a running divide, and timeouts.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      n = 0;
      running = 0;
      startCyc = 0;
      busyEnd = -1;
      waitFrom = 1;
      evq.delete();
      expPeriod = 0;
      expHigh = 0;
      expDuty = 0;
      expNs = 1'b1;
    end else begin
      n++;
      if (n >= MAXCYC) begin
        $display("[TB] FAIL cycle_budget: got %0d, expected below %0d", n, MAXCYC);
        $fatal(1, "[TB] model history overflow");
      end
      pwmHist[n] = pwm_in;
      lvlHist[n] = lvlAt(n);
      mPrev = (n > 1) ? lvlHist[n-1] : 1'b0;
      mRise = lvlHist[n] && !mPrev;
      if (running == 0) begin
        if (mRise && n >= waitFrom) begin
          running = 1;
          startCyc = n;
        end
      end else begin
        if (mRise) begin
          if (n > busyEnd) begin
            mP = n - startCyc;
            mH = 0;
            for (int k = startCyc + 1; k <= n; k++) mH += lvlHist[k];
            mQ = (longint'(mH) * 1000) / mP;
            if (mQ > 1000) mQ = 1000;
            mEv.at = n + LAT;
            mEv.per = mP;
            mEv.hi = mH;
            mEv.dut = int'(mQ);
            mEv.ns = 1'b0;
            evq.push_back(mEv);
            busyEnd = n + LAT - 1;
          end
          startCyc = n;
        end else if (n > busyEnd && n - startCyc == TIMEOUT) begin
          mEv.at = n + 2;
          mEv.per = 0;
          mEv.hi = 0;
          mEv.dut = lvlAt(n + 1) ? 1000 : 0;
          mEv.ns = 1'b1;
          evq.push_back(mEv);
          running = 0;
          waitFrom = n + 2;
        end
      end
    end
  end

  // Every-cycle comparison against the model, on the inactive clock edge.
  always @(negedge clock) begin
    if (!reset) begin
      validSeen = 0;
      checkOutput("rst_level", int'(level), 0);
      checkOutput("rst_valid", int'(valid), 0);
      checkOutput("rst_period", int'(period), 0);
      checkOutput("rst_high_time", int'(high_time), 0);
      checkOutput("rst_duty", int'(duty), 0);
      checkOutput("rst_no_signal", int'(no_signal), 1);
    end else begin
      expValid = 1'b0;
      if (evq.size() > 0 && evq[0].at == n) begin
        expPeriod = evq[0].per;
        expHigh = evq[0].hi;
        expDuty = evq[0].dut;
        expNs = evq[0].ns;
        expValid = 1'b1;
        void'(evq.pop_front());
      end
      expLevel = (n >= 1) ? lvlHist[n] : 1'b0;
      if (valid) validSeen++;
      checkOutput("level", int'(level), int'(expLevel));
      checkOutput("valid", int'(valid), int'(expValid));
      checkOutput("period", int'(period), expPeriod);
      checkOutput("high_time", int'(high_time), expHigh);
      checkOutput("duty", int'(duty), expDuty);
      checkOutput("no_signal", int'(no_signal), int'(expNs));
    end
  end

  task automatic applyStimulus(input int per, input int hi, input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int c = 0; c < per; c++) begin
        @(negedge clock);
        pwm_in = (c < hi);
      end
    end
  endtask

  task automatic holdInput(input bit v, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clock);
      pwm_in = v;
    end
  endtask

  task automatic applyReset();
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    checkOutput("async_rst_valid", int'(valid), 0);
    checkOutput("async_rst_no_signal", int'(no_signal), 1);
    checkOutput("async_rst_period", int'(period), 0);
    repeat (3) @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
  endtask

  task automatic checkHeld(input string tag, input int per, input int hi, input int dt, input int ns);
    #1;
    checkOutput({tag, "_period"}, int'(period), per);
    checkOutput({tag, "_high_time"}, int'(high_time), hi);
    checkOutput({tag, "_duty"}, int'(duty), dt);
    checkOutput({tag, "_no_signal"}, int'(no_signal), ns);
  endtask

  initial begin
    $display("[TB] pwm_capture test start");
    repeat (3) @(negedge clock);
    checkHeld("reset", 0, 0, 0, 1);
    @(posedge clock);
    #2 reset = 1'b1;

    // 1: half duty at 5000 cycles
    applyStimulus(5000, 2500, 3);
    checkHeld("t1", 5000, 2500, 500, 0);

    // 2: extreme duties
    applyStimulus(5000, 5, 2);
    checkHeld("t2a", 5000, 5, 1, 0);
    applyStimulus(5000, 4999, 2);
    checkHeld("t2b", 5000, 4999, 999, 0);

    // 3: stuck high, timeout, then recovery after two edges
    applyStimulus(5000, 2500, 1);
    holdInput(1'b1, TIMEOUT + 100);
    checkHeld("t3_timeout", 0, 0, 1000, 1);
    applyStimulus(500, 100, 2);
    checkHeld("t3_one_edge", 0, 0, 1000, 1);
    applyStimulus(500, 100, 1);
    checkHeld("t3_recovered", 500, 100, 200, 0);

    // 4: period shorter than the divide latency
    applyStimulus(20, 10, 20);
    checkHeld("t4", 20, 10, 500, 0);

    // 5: reset in the middle of a divide
    applyStimulus(300, 100, 2);
    holdInput(1'b1, 8);
    applyReset();
    #1;
    checkOutput("t5_after_rst_no_signal", int'(no_signal), 1);
    applyStimulus(300, 100, 3);
    checkHeld("t5", 300, 100, 333, 0);

    // 6: single-cycle pulses floor to zero duty
    applyStimulus(5000, 1, 2);
    checkHeld("t6", 5000, 1, 0, 0);

    // 6b: idle low from reset never reports; first edge then timeout
    pwm_in = 1'b0;
    applyReset();
    holdInput(1'b0, TIMEOUT + 200);
    checkOutput("t6_idle_valids", validSeen, 0);
    checkHeld("t6_idle", 0, 0, 0, 1);
    holdInput(1'b1, 1);
    holdInput(1'b0, TIMEOUT - 100);
    checkOutput("t6_pre_timeout_valids", validSeen, 0);
    holdInput(1'b0, 150);
    checkOutput("t6_timeout_valids", validSeen, 1);
    checkHeld("t6_timeout", 0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
